ekf_stage_scheduler: RTL and testbench

- Sequences the EKF-SLAM datapath (RSA array plus NonLinear unit) from a queue of host-issued steps: predict, new-landmark, update.
- Buffers commands, validates landmark indices, and drives the RSA stage handshake one stage at a time.
- Holds the per-stage operands (vlr/alpha or rk/phi, l_k) stable for the whole stage.
- Owns the authoritative landmark count; the datapath top instantiates it between the host interface and the RSA stage ports.

---
 rtl/ekf_sched_pkg.sv | 40 ++++
 rtl/sched_cmd_fifo.sv | 53 +++++
 rtl/ekf_stage_scheduler.sv | 224 ++++++++++++++++++++++
 tb/tb_ekf_stage_scheduler.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ekf_sched_pkg.sv
// ekf_sched_pkg
// Shared encodings for the EKF stage scheduler: host op codes, FSM states,
// one-hot RSA stage requests and error codes.
package ekf_sched_pkg;

  localparam logic [1:0] OP_PREDICT = 2'd0;
  localparam logic [1:0] OP_NEWLM   = 2'd1;
  localparam logic [1:0] OP_UPDATE  = 2'd2;
  localparam logic [1:0] OP_RSVD    = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_CHECK     = 2'd1,
    ST_ISSUE     = 2'd2,
    ST_WAIT_DONE = 2'd3
  } sched_state_e;

  localparam logic [2:0] STAGE_NONE    = 3'b000;
  localparam logic [2:0] STAGE_PREDICT = 3'b001;
  localparam logic [2:0] STAGE_NEWLM   = 3'b010;
  localparam logic [2:0] STAGE_UPDATE  = 3'b100;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_BAD_OP  = 2'd1;
  localparam logic [1:0] ERR_BAD_LK  = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  // Reserved op maps to no stage so it can never raise a request.
  function automatic logic [2:0] stage_onehot(input logic [1:0] op);
    logic [2:0] sel;
    case (op)
      OP_PREDICT: sel = STAGE_PREDICT;
      OP_NEWLM:   sel = STAGE_NEWLM;
      OP_UPDATE:  sel = STAGE_UPDATE;
      default:    sel = STAGE_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/sched_cmd_fifo.sv
// sched_cmd_fifo
// Synchronous command FIFO for the stage scheduler.
// Ports:
//   clk_sys, rst_b       clock, async active-low reset
//   push, push_data      write strobe / payload (ignored when full)
//   pop, pop_data        read strobe (ignored when empty) / head entry
//   full, empty          occupancy flags
module sched_cmd_fifo
  import ekf_sched_pkg::*;
#(
  parameter int DW    = 86,
  parameter int DEPTH = 4
) (
  input  logic          clk_sys,
  input  logic          rst_b,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] pop_data,
  output logic          full,
  output logic          empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  // One extra pointer bit distinguishes full from empty when the indices match.
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk_sys or negedge rst_b) begin
    if (!rst_b) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk_sys) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/ekf_stage_scheduler.sv
// ekf_stage_scheduler
// Dispatches queued host steps (predict / new-landmark / update) to the RSA
// datapath one stage at a time, validating landmark indices and owning the
// map landmark count.
// Ports:
//   clk, sys_rst                       clock, async active-low reset
//   cmd_valid/cmd_ready, cmd_op,
//   cmd_lk, cmd_d0, cmd_d1             host command push interface
//   clear_map                          zero the map (only when idle and queue empty)
//   stage_val, stage_rdy               one-hot stage request / RSA per-stage ready level
//   landmark_num, l_k                  map landmark count / active landmark index
//   vlr, alpha, rk, phi                operands held for the running stage
//   busy, done, done_op, err, err_code status and completion / error pulses
//
// state        | meaning
// ST_IDLE      | waiting for a queued command; pops head into operand regs
// ST_CHECK     | validates op and landmark index, selects l_k
// ST_ISSUE     | stage_val asserted until RSA drops ready or watchdog expires
// ST_WAIT_DONE | RSA busy; waits for ready to return, then signals done
module ekf_stage_scheduler
  import ekf_sched_pkg::*;
#(
  parameter int RSA_DW    = 32,
  parameter int ROW_LEN   = 10,
  parameter int CMD_DEPTH = 4,
  parameter int TIMEOUT   = 1024,
  parameter int TO_W      = 11
) (
  input  logic               clk,
  input  logic               sys_rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [ROW_LEN-1:0] cmd_lk,
  input  logic [RSA_DW-1:0]  cmd_d0,
  input  logic [RSA_DW-1:0]  cmd_d1,
  input  logic               clear_map,
  output logic [2:0]         stage_val,
  input  logic [2:0]         stage_rdy,
  output logic [ROW_LEN-1:0] landmark_num,
  output logic [ROW_LEN-1:0] l_k,
  output logic [RSA_DW-1:0]  vlr,
  output logic [RSA_DW-1:0]  alpha,
  output logic [RSA_DW-1:0]  rk,
  output logic [RSA_DW-1:0]  phi,
  output logic               busy,
  output logic               done,
  output logic [1:0]         done_op,
  output logic               err,
  output logic [1:0]         err_code
);

  localparam int FW = 2 + ROW_LEN + 2*RSA_DW;

  sched_state_e       state_q, state_d;

  logic [FW-1:0]      fifo_wdata;
  logic [FW-1:0]      fifo_rdata;
  logic               fifo_full;
  logic               fifo_empty;
  logic               fifo_push;
  logic               fifo_pop;
  logic [1:0]         head_op;
  logic [ROW_LEN-1:0] head_lk;
  logic [RSA_DW-1:0]  head_d0;
  logic [RSA_DW-1:0]  head_d1;

  logic               rdy_q;
  logic [1:0]         op_q;
  logic [ROW_LEN-1:0] lk_q;
  logic [TO_W-1:0]    wd_q;

  logic               rdy_bit;
  logic               lk_bad;
  logic               map_full;
  logic               enter_issue;
  logic               leave_issue;
  logic               wd_dec;
  logic               set_err;
  logic [1:0]         err_code_d;
  logic               set_done;
  logic               lm_inc;
  logic               lm_clr;

  // Held low for the first cycle after reset release so all outputs read 0 in reset.
  assign cmd_ready  = rdy_q && !fifo_full;
  assign fifo_push  = cmd_valid && cmd_ready;
  assign fifo_wdata = {cmd_op, cmd_lk, cmd_d0, cmd_d1};
  assign {head_op, head_lk, head_d0, head_d1} = fifo_rdata;

  sched_cmd_fifo #(
    .DW    (FW),
    .DEPTH (CMD_DEPTH)
  ) u_cmd_fifo (
    .clk_sys   (clk),
    .rst_b     (sys_rst),
    .push      (fifo_push),
    .push_data (fifo_wdata),
    .pop       (fifo_pop),
    .pop_data  (fifo_rdata),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign busy     = (state_q != ST_IDLE) || !fifo_empty;
  assign rdy_bit  = |(stage_rdy & stage_onehot(op_q));
  assign lk_bad   = (op_q == OP_UPDATE) && (lk_q >= landmark_num);
  assign map_full = (landmark_num == {ROW_LEN{1'b1}});
  assign lm_clr   = clear_map && (state_q == ST_IDLE) && fifo_empty;

  always_ff @(posedge clk or negedge sys_rst) begin
    if (!sys_rst) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    fifo_pop    = 1'b0;
    enter_issue = 1'b0;
    leave_issue = 1'b0;
    wd_dec      = 1'b0;
    set_err     = 1'b0;
    err_code_d  = ERR_NONE;
    set_done    = 1'b0;
    lm_inc      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = ST_CHECK;
        end
      end
      ST_CHECK: begin
        state_d = ST_IDLE;
        if (op_q == OP_RSVD) begin
          set_err    = 1'b1;
          err_code_d = ERR_BAD_OP;
        end else if (lk_bad || ((op_q == OP_NEWLM) && map_full)) begin
          set_err    = 1'b1;
          err_code_d = ERR_BAD_LK;
        end else begin
          enter_issue = 1'b1;
          state_d     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // RSA accepting the stage wins over a watchdog expiring in the same cycle.
        if (!rdy_bit) begin
          leave_issue = 1'b1;
          state_d     = ST_WAIT_DONE;
        end else if (wd_q == '0) begin
          leave_issue = 1'b1;
          set_err     = 1'b1;
          err_code_d  = ERR_TIMEOUT;
          state_d     = ST_IDLE;
        end else begin
          wd_dec = 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        if (rdy_bit) begin
          set_done = 1'b1;
          lm_inc   = (op_q == OP_NEWLM);
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge sys_rst) begin
    if (!sys_rst) begin
      rdy_q        <= 1'b0;
      op_q         <= OP_PREDICT;
      lk_q         <= '0;
      l_k          <= '0;
      vlr          <= '0;
      alpha        <= '0;
      rk           <= '0;
      phi          <= '0;
      stage_val    <= STAGE_NONE;
      wd_q         <= '0;
      landmark_num <= '0;
      done         <= 1'b0;
      done_op      <= OP_PREDICT;
      err          <= 1'b0;
      err_code     <= ERR_NONE;
    end else begin
      rdy_q    <= 1'b1;
      done     <= set_done;
      done_op  <= set_done ? op_q : OP_PREDICT;
      err      <= set_err;
      err_code <= set_err ? err_code_d : ERR_NONE;

      if (fifo_pop) begin
        op_q <= head_op;
        lk_q <= head_lk;
        if (head_op == OP_PREDICT) begin
          vlr   <= head_d0;
          alpha <= head_d1;
        end else begin
          rk  <= head_d0;
          phi <= head_d1;
        end
      end

      if (enter_issue) begin
        stage_val <= stage_onehot(op_q);
        // Down-counter reaches zero after TIMEOUT cycles in ISSUE.
        wd_q      <= TO_W'(TIMEOUT - 1);
        if (op_q == OP_NEWLM)       l_k <= landmark_num;
        else if (op_q == OP_UPDATE) l_k <= lk_q;
      end else if (leave_issue) begin
        stage_val <= STAGE_NONE;
      end

      if (wd_dec) wd_q <= wd_q - TO_W'(1);

      if (lm_clr)      landmark_num <= '0;
      else if (lm_inc) landmark_num <= landmark_num + ROW_LEN'(1);
    end
  end

endmodule

// File: tb/tb_ekf_stage_scheduler.sv
module tb_ekf_stage_scheduler;
  import ekf_sched_pkg::*;

  localparam int RSA_DW    = 32;
  localparam int ROW_LEN   = 10;
  localparam int CMD_DEPTH = 4;
  localparam int TIMEOUT   = 1024;
  localparam int TO_W      = 11;

  logic               clk = 1'b0;
  logic               sys_rst = 1'b0;
  logic               cmd_valid = 1'b0;
  logic               cmd_ready;
  logic [1:0]         cmd_op = 2'd0;
  logic [ROW_LEN-1:0] cmd_lk = '0;
  logic [RSA_DW-1:0]  cmd_d0 = '0;
  logic [RSA_DW-1:0]  cmd_d1 = '0;
  logic               clear_map = 1'b0;
  logic [2:0]         stage_val;
  logic [2:0]         stage_rdy = 3'b111;
  logic [ROW_LEN-1:0] landmark_num;
  logic [ROW_LEN-1:0] l_k;
  logic [RSA_DW-1:0]  vlr, alpha, rk, phi;
  logic               busy, done, err;
  logic [1:0]         done_op, err_code;

  ekf_stage_scheduler #(
    .RSA_DW(RSA_DW), .ROW_LEN(ROW_LEN), .CMD_DEPTH(CMD_DEPTH),
    .TIMEOUT(TIMEOUT), .TO_W(TO_W)
  ) dut (
    .clk(clk), .sys_rst(sys_rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_lk(cmd_lk), .cmd_d0(cmd_d0), .cmd_d1(cmd_d1),
    .clear_map(clear_map),
    .stage_val(stage_val), .stage_rdy(stage_rdy),
    .landmark_num(landmark_num), .l_k(l_k),
    .vlr(vlr), .alpha(alpha), .rk(rk), .phi(phi),
    .busy(busy), .done(done), .done_op(done_op), .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // RSA model: drop ready drop_dly cycles after a request, restore busy_len later.
  int         drop_dly  = 2;
  int         busy_len  = 50;
  logic       rsa_hold  = 1'b0;
  logic       rsa_stall = 1'b0;
  int         rsa_ph    = 0;
  int         rsa_cnt   = 0;
  logic [2:0] rsa_sel   = 3'b000;

  always @(negedge clk) begin
    if (!sys_rst) begin
      stage_rdy = 3'b111;
      rsa_ph    = 0;
      rsa_cnt   = 0;
    end else begin
      case (rsa_ph)
        0: if (stage_val != 3'b000 && !rsa_hold) begin
             rsa_sel = stage_val;
             rsa_cnt = 1;
             rsa_ph  = 1;
           end
        1: if (rsa_cnt >= drop_dly) begin
             stage_rdy = stage_rdy & ~rsa_sel;
             rsa_cnt   = 0;
             rsa_ph    = 2;
           end else rsa_cnt++;
        default: begin
          rsa_cnt++;
          if (!rsa_stall && rsa_cnt >= busy_len) begin
            stage_rdy = 3'b111;
            rsa_ph    = 0;
          end
        end
      endcase
    end
  end

  logic [1:0] done_q[$];
  logic [1:0] err_q[$];
  int         sv_cycles = 0;

  always @(negedge clk) begin
    if (sys_rst) begin
      if (done) done_q.push_back(done_op);
      if (err)  err_q.push_back(err_code);
      if (done || err) check("done_err_excl", 64'(done && err), 64'd0);
      if (stage_val != 3'b000) sv_cycles++;
    end
  end

  task automatic push(input logic [1:0] op, input logic [ROW_LEN-1:0] lk,
                      input logic [RSA_DW-1:0] d0, input logic [RSA_DW-1:0] d1);
    int n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 5000) begin @(negedge clk); n++; end
    if (!cmd_ready) check("push_timeout", 64'd0, 64'd1);
    cmd_valid = 1'b1; cmd_op = op; cmd_lk = lk; cmd_d0 = d0; cmd_d1 = d1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, output logic [1:0] op);
    int n = 0;
    while (done_q.size() == 0 && n < 3000) begin @(negedge clk); n++; end
    if (done_q.size() == 0) begin
      check({tag, "_timeout"}, 64'd0, 64'd1);
      op = 2'b11;
    end else op = done_q.pop_front();
  endtask

  task automatic wait_err(input string tag, input int lim, output logic [1:0] code);
    int n = 0;
    while (err_q.size() == 0 && n < lim) begin @(negedge clk); n++; end
    if (err_q.size() == 0) begin
      check({tag, "_timeout"}, 64'd0, 64'd1);
      code = 2'b00;
    end else code = err_q.pop_front();
  endtask

  task automatic wait_sv(input string tag, output int lat);
    lat = 0;
    while (stage_val == 3'b000 && lat < 50) begin @(negedge clk); lat++; end
    if (stage_val == 3'b000) check({tag, "_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic wait_sv_low(input string tag);
    int n = 0;
    while (stage_val != 3'b000 && n < 50) begin @(negedge clk); n++; end
    if (stage_val != 3'b000) check({tag, "_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 20000) begin @(negedge clk); n++; end
    if (busy) check({tag, "_timeout"}, 64'd0, 64'd1);
  endtask

  logic [1:0]         b_op [5] = '{2'd1, 2'd2, 2'd0, 2'd1, 2'd0};
  logic [ROW_LEN-1:0] b_lk [5] = '{10'd0, 10'd1, 10'd0, 10'd0, 10'd0};

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    logic [1:0] op;
    logic [1:0] code;
    int lat;
    int acc;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    check("rst_stage_val", 64'(stage_val), 64'd0);
    check("rst_lm", 64'(landmark_num), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    sys_rst = 1'b1;
    @(negedge clk);
    check("rdy_after_rst", 64'(cmd_ready), 64'd1);

    // Predict dispatch
    sv_cycles = 0;
    push(OP_PREDICT, '0, 32'h100, 32'h20);
    wait_sv("pred_sv", lat);
    check("pred_dispatch_lat", 64'(lat <= 2), 64'd1);
    check("pred_stage_val", 64'(stage_val), 64'b001);
    check("pred_vlr", 64'(vlr), 64'h100);
    check("pred_alpha", 64'(alpha), 64'h20);
    wait_done("pred_done", op);
    check("pred_done_op", 64'(op), 64'd0);
    check("pred_vlr_hold", 64'(vlr), 64'h100);
    check("pred_alpha_hold", 64'(alpha), 64'h20);
    check("pred_lm", 64'(landmark_num), 64'd0);
    check("pred_issue_cycles", 64'(sv_cycles), 64'd3);

    // Newlm then update lk=0
    push(OP_NEWLM, '0, 32'h11, 32'h22);
    push(OP_UPDATE, 10'd0, 32'h33, 32'h44);
    wait_sv("nl_sv", lat);
    check("nl_stage_val", 64'(stage_val), 64'b010);
    check("nl_l_k", 64'(l_k), 64'd0);
    check("nl_rk", 64'(rk), 64'h11);
    check("nl_phi", 64'(phi), 64'h22);
    wait_done("nl_done", op);
    check("nl_done_op", 64'(op), 64'd1);
    check("nl_lm", 64'(landmark_num), 64'd1);
    wait_sv("up_sv", lat);
    check("up_stage_val", 64'(stage_val), 64'b100);
    check("up_l_k", 64'(l_k), 64'd0);
    check("up_rk", 64'(rk), 64'h33);
    check("up_vlr_kept", 64'(vlr), 64'h100);
    wait_done("up_done", op);
    check("up_done_op", 64'(op), 64'd2);

    // Bad index, then queued predict proceeds
    wait_idle("pre_bad");
    sv_cycles = 0;
    push(OP_UPDATE, 10'd5, 32'h55, 32'h66);
    push(OP_PREDICT, '0, 32'h200, 32'h40);
    wait_err("bad_lk_err", 100, code);
    check("bad_lk_code", 64'(code), 64'd2);
    check("bad_lk_no_issue", 64'(sv_cycles), 64'd0);
    wait_sv("after_bad_sv", lat);
    check("after_bad_stage_val", 64'(stage_val), 64'b001);
    check("after_bad_vlr", 64'(vlr), 64'h200);
    wait_done("after_bad_done", op);
    check("after_bad_done_op", 64'(op), 64'd0);
    check("after_bad_lm", 64'(landmark_num), 64'd1);

    // lk == landmark_num boundary and reserved op
    wait_idle("pre_edge");
    sv_cycles = 0;
    push(OP_UPDATE, 10'd1, 32'h77, 32'h88);
    wait_err("lk_eq_err", 100, code);
    check("lk_eq_code", 64'(code), 64'd2);
    push(OP_RSVD, '0, 32'h0, 32'h0);
    wait_err("rsvd_err", 100, code);
    check("rsvd_code", 64'(code), 64'd1);
    wait_idle("post_edge");
    check("edge_no_issue", 64'(sv_cycles), 64'd0);
    check("edge_no_done", 64'(done_q.size()), 64'd0);

    // Fill and burst while RSA is stalled
    rsa_stall = 1'b1;
    busy_len  = 2;
    push(OP_PREDICT, '0, 32'h300, 32'h60);
    wait_sv("fill_sv", lat);
    wait_sv_low("fill_sv_low");
    acc = 0;
    for (int i = 0; i < 5; i++) begin
      cmd_valid = 1'b1; cmd_op = b_op[i]; cmd_lk = b_lk[i];
      cmd_d0 = 32'(i); cmd_d1 = 32'(i);
      if (cmd_ready) acc++;
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    check("burst_accepted", 64'(acc), 64'd4);
    check("burst_ready_low", 64'(cmd_ready), 64'd0);
    rsa_stall = 1'b0;
    wait_done("burst_d0", op); check("burst_op0", 64'(op), 64'd0);
    wait_done("burst_d1", op); check("burst_op1", 64'(op), 64'd1);
    wait_done("burst_d2", op); check("burst_op2", 64'(op), 64'd2);
    wait_done("burst_d3", op); check("burst_op3", 64'(op), 64'd0);
    wait_done("burst_d4", op); check("burst_op4", 64'(op), 64'd1);
    wait_idle("burst_idle");
    check("burst_lm", 64'(landmark_num), 64'd3);
    check("burst_no_err", 64'(err_q.size()), 64'd0);

    // clear_map ignored while busy, honoured when idle
    rsa_stall = 1'b1;
    push(OP_PREDICT, '0, 32'h400, 32'h80);
    wait_sv("clr_sv", lat);
    wait_sv_low("clr_sv_low");
    clear_map = 1'b1;
    @(negedge clk);
    clear_map = 1'b0;
    @(negedge clk);
    check("clr_busy_ignored", 64'(landmark_num), 64'd3);
    rsa_stall = 1'b0;
    wait_done("clr_done", op);
    wait_idle("clr_idle");
    clear_map = 1'b1;
    @(negedge clk);
    clear_map = 1'b0;
    check("clr_lm_zero", 64'(landmark_num), 64'd0);

    // Fill the map to its limit
    drop_dly = 1;
    busy_len = 1;
    for (int i = 0; i < 1023; i++) push(OP_NEWLM, '0, 32'(i), 32'(i));
    wait_idle("full_idle");
    @(negedge clk);
    check("full_lm", 64'(landmark_num), 64'd1023);
    check("full_done_count", 64'(done_q.size()), 64'd1023);
    done_q.delete();
    push(OP_NEWLM, '0, 32'h1, 32'h2);
    wait_err("full_err", 100, code);
    check("full_code", 64'(code), 64'd2);
    check("full_lm_hold", 64'(landmark_num), 64'd1023);

    // Watchdog timeout
    wait_idle("pre_to");
    rsa_hold  = 1'b1;
    sv_cycles = 0;
    push(OP_PREDICT, '0, 32'h500, 32'h90);
    wait_err("to_err", TIMEOUT + 50, code);
    check("to_code", 64'(code), 64'd3);
    check("to_stage_val", 64'(stage_val), 64'd0);
    check("to_lm", 64'(landmark_num), 64'd1023);
    check("to_issue_cycles", 64'(sv_cycles), 64'(TIMEOUT));
    check("to_no_done", 64'(done_q.size()), 64'd0);
    rsa_hold = 1'b0;

    // Reset during WAIT_DONE with a command still queued
    wait_idle("pre_rst");
    rsa_stall = 1'b1;
    drop_dly  = 2;
    push(OP_UPDATE, 10'd5, 32'hAA, 32'hBB);
    wait_sv("rst_sv", lat);
    check("rst_up_l_k", 64'(l_k), 64'd5);
    wait_sv_low("rst_sv_low");
    push(OP_PREDICT, '0, 32'h600, 32'hA0);
    check("rst_busy_before", 64'(busy), 64'd1);
    sys_rst = 1'b0;
    #1;
    check("mid_rst_stage_val", 64'(stage_val), 64'd0);
    check("mid_rst_lm", 64'(landmark_num), 64'd0);
    check("mid_rst_l_k", 64'(l_k), 64'd0);
    check("mid_rst_ops", 64'(vlr | alpha | rk | phi), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_ready", 64'(cmd_ready), 64'd0);
    check("mid_rst_pulses", 64'({done, err, done_op, err_code}), 64'd0);
    rsa_stall = 1'b0;
    repeat (2) @(negedge clk);
    sys_rst   = 1'b1;
    sv_cycles = 0;
    repeat (10) @(negedge clk);
    check("post_rst_fifo_empty", 64'(busy), 64'd0);
    check("post_rst_no_issue", 64'(sv_cycles), 64'd0);
    check("post_rst_ready", 64'(cmd_ready), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
